// File: rtl/cache_pkg.sv
// cache_pkg: shared cache encodings, block geometry and refill FSM states.
package cache_pkg;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int WORD_IDX_W = 2;
    localparam int BYTE_OFF_W = 2;
    localparam int BLOCK_OFF_W = WORD_IDX_W + BYTE_OFF_W;
    typedef enum logic [2:0] {IDLE, GRANT, EVICT, FILL, DRAIN} mm_state_t;
    typedef enum logic [1:0] {MESI_I = 2'b00, MESI_S = 2'b01, MESI_M = 2'b10, MESI_E = 2'b11} mesi_t;
endpackage

// File: rtl/mm_refill_responder.sv
// mm_refill_responder: serves a cache miss by writing back a dirty victim block
// and refilling the missing block, one word per cycle, from a 1-cycle-latency memory.
module mm_refill_responder #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK
) (
    input  logic                                       clk,
    input  logic                                       nrst,
    input  logic                                       i_req,
    input  logic                                       i_evict_en,
    input  logic [ADDR_WIDTH-cache_pkg::BLOCK_OFF_W-1:0] i_refill_addr,
    input  logic [ADDR_WIDTH-cache_pkg::BLOCK_OFF_W-1:0] i_evict_addr,
    input  logic [DATA_WIDTH-1:0]                      i_evict_word,
    output logic                                       o_readymm,
    output logic [1:0]                                 o_word_idx,
    output logic                                       o_refill_valid,
    output logic [DATA_WIDTH-1:0]                      o_refill_word,
    output logic                                       o_done_mm,
    output logic [ADDR_WIDTH-3:0]                      o_mem_addr,
    output logic                                       o_mem_we,
    output logic [DATA_WIDTH-1:0]                      o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]                      i_mem_rdata
);
    import cache_pkg::*;
    localparam int BW = ADDR_WIDTH - BLOCK_OFF_W;
    localparam logic [WORD_IDX_W-1:0] LAST = WORD_IDX_W'(WORDS_PER_BLOCK - 1);
    mm_state_t state, state_d;
    logic [WORD_IDX_W-1:0] cnt, cnt_d, rd_idx;
    logic ev_flag, rd_pend;
    logic [BW-1:0] refill_q, evict_q;
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            cnt      <= '0;
            ev_flag  <= 1'b0;
            refill_q <= '0;
            evict_q  <= '0;
            rd_pend  <= 1'b0;
            rd_idx   <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            rd_pend <= state == FILL;
            rd_idx  <= cnt;
            if (state == GRANT) begin
                ev_flag  <= i_evict_en;
                refill_q <= i_refill_addr;
                evict_q  <= i_evict_addr;
            end
        end
    end
    // The GRANT decision uses the value being latched on this same edge.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                cnt_d   = '0;
                state_d = i_req ? GRANT : IDLE;
            end
            GRANT: state_d = i_evict_en ? EVICT : FILL;
            EVICT: begin
                cnt_d   = cnt + 1'b1;
                state_d = cnt == LAST ? FILL : EVICT;
            end
            FILL: begin
                cnt_d   = cnt + 1'b1;
                state_d = cnt == LAST ? DRAIN : FILL;
            end
            default: state_d = IDLE;
        endcase
    end
    assign o_readymm      = state == GRANT;
    assign o_done_mm      = state == DRAIN;
    assign o_refill_valid = rd_pend;
    assign o_refill_word  = rd_pend ? i_mem_rdata : '0;
    assign o_mem_we       = state == EVICT && ev_flag;
    assign o_mem_wdata    = o_mem_we ? i_evict_word : '0;
    assign o_word_idx     = state == EVICT ? cnt : rd_pend ? rd_idx : '0;
    assign o_mem_addr     = state == EVICT ? {evict_q, cnt} : state == FILL ? {refill_q, cnt} : '0;
endmodule

// File: tb/tb_mm_refill_responder.sv
// tb_mm_refill_responder: randomized self-checking bench with a word-level memory
// model; expectations come from block/word arithmetic and a fixed cycle timeline.
module tb_mm_refill_responder;
    localparam int AW = 14, DW = 32, BW = AW - 4, MW = AW - 2;
    logic clk = 1'b0, nrst;
    logic i_req, i_evict_en;
    logic [BW-1:0] i_refill_addr, i_evict_addr;
    logic [DW-1:0] i_evict_word, i_mem_rdata;
    logic o_readymm, o_refill_valid, o_done_mm, o_mem_we;
    logic [1:0] o_word_idx;
    logic [DW-1:0] o_refill_word, o_mem_wdata;
    logic [MW-1:0] o_mem_addr;
    logic [DW-1:0] mem [0:(1<<MW)-1];
    logic [DW-1:0] victim [0:3];
    int checks = 0, errors = 0, wr_cnt = 0;

    mm_refill_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_BLOCK(4)) dut (
        .clk(clk), .nrst(nrst), .i_req(i_req), .i_evict_en(i_evict_en),
        .i_refill_addr(i_refill_addr), .i_evict_addr(i_evict_addr), .i_evict_word(i_evict_word),
        .o_readymm(o_readymm), .o_word_idx(o_word_idx), .o_refill_valid(o_refill_valid),
        .o_refill_word(o_refill_word), .o_done_mm(o_done_mm), .o_mem_addr(o_mem_addr),
        .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata));

    always #5 clk = ~clk;
    assign i_evict_word = victim[o_word_idx];
    always @(posedge clk) begin
        if (o_mem_we) begin
            mem[o_mem_addr] <= o_mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        i_mem_rdata <= mem[o_mem_addr];
    end

    task automatic test_reset();
        nrst = 1'b1; i_req = 1'b1; i_evict_en = 1'b1;
        i_refill_addr = '0; i_evict_addr = '0; i_mem_rdata = '0;
        #1 nrst = 1'b0;
        #1;
        checks++;
        if ({o_readymm, o_word_idx, o_refill_valid, o_refill_word, o_done_mm, o_mem_addr, o_mem_we, o_mem_wdata} !== '0) begin
            errors++; $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
        end
        repeat (3) @(negedge clk);
        i_req = 1'b0; i_evict_en = 1'b0; nrst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (o_readymm !== 1'b0 || o_done_mm !== 1'b0) begin
                errors++; $display("FAIL reset_no_grant: c=%0d readymm=%b done=%b, expected 0", c, o_readymm, o_done_mm);
            end
        end
    endtask

    task automatic test_miss(input string tag, input logic dirty, input logic [BW-1:0] ra, input logic [BW-1:0] ea,
                             input logic glitch);
        logic [DW-1:0] exp_w [4];
        int grants = 0, grant_c = -1, dones = 0, done_c = -1, nref = 0, nwr = 0;
        int fs = dirty ? 6 : 2;
        int exp_done = dirty ? 10 : 6;
        for (int k = 0; k < 4; k++) exp_w[k] = (dirty && ra == ea) ? victim[k] : mem[{ra, 2'(k)}];
        @(negedge clk);
        i_req = 1'b1; i_evict_en = dirty; i_refill_addr = ra; i_evict_addr = ea;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1 if (c == 1) i_req = 1'b0;
            @(negedge clk);
            if (o_readymm) begin grants++; grant_c = c; end
            if (o_done_mm) begin dones++; done_c = c; end
            if (o_mem_we) begin
                checks++;
                if (!dirty || c < 2 || c > 5) begin
                    errors++; $display("FAIL %s stray_write: c=%0d addr=%h, expected no write", tag, c, o_mem_addr);
                end else if (o_mem_addr !== {ea, 2'(c-2)} || o_mem_wdata !== victim[c-2] || o_word_idx !== 2'(c-2)) begin
                    errors++;
                    $display("FAIL %s write: c=%0d got addr=%h data=%h idx=%0d expected addr=%h data=%h idx=%0d",
                             tag, c, o_mem_addr, o_mem_wdata, o_word_idx, {ea, 2'(c-2)}, victim[c-2], c-2);
                end
                nwr++;
            end
            if (c >= fs && c < fs + 4) begin
                checks++;
                if (o_mem_we !== 1'b0 || o_mem_addr !== {ra, 2'(c-fs)}) begin
                    errors++;
                    $display("FAIL %s read_issue: c=%0d got we=%b addr=%h expected we=0 addr=%h", tag, c, o_mem_we, o_mem_addr, {ra, 2'(c-fs)});
                end
            end
            if (o_refill_valid) begin
                checks++;
                if (nref > 3) begin
                    errors++; $display("FAIL %s extra_refill: c=%0d got word %0d, expected only 4", tag, c, nref);
                end else if (o_word_idx !== 2'(nref) || o_refill_word !== exp_w[nref] || c != fs + 1 + nref) begin
                    errors++;
                    $display("FAIL %s refill: c=%0d got idx=%0d word=%h expected c=%0d idx=%0d word=%h",
                             tag, c, o_word_idx, o_refill_word, fs + 1 + nref, nref, exp_w[nref]);
                end
                nref++;
            end
            if (glitch && c >= 2) begin
                i_evict_en = 1'($urandom); i_refill_addr = BW'($urandom); i_evict_addr = BW'($urandom);
            end
        end
        checks++;
        if (grants != 1 || grant_c != 1) begin
            errors++; $display("FAIL %s grant: got %0d grants at c=%0d, expected 1 at c=1", tag, grants, grant_c);
        end
        checks++;
        if (dones != 1 || done_c != exp_done) begin
            errors++; $display("FAIL %s done: got %0d at c=%0d, expected 1 at c=%0d", tag, dones, done_c, exp_done);
        end
        checks++;
        if (nwr != (dirty ? 4 : 0)) begin
            errors++; $display("FAIL %s write_count: got %0d expected %0d", tag, nwr, dirty ? 4 : 0);
        end
        checks++;
        if (nref != 4) begin
            errors++; $display("FAIL %s refill_count: got %0d expected 4", tag, nref);
        end
        i_evict_en = 1'b0;
    endtask

    task automatic test_clean_miss();
        for (int k = 0; k < 4; k++) mem[12'h154 + k] = 32'hA0 + k;
        test_miss("clean", 1'b0, 10'h055, 10'h2AA, 1'b0);
    endtask

    task automatic test_dirty_miss();
        for (int k = 0; k < 4; k++) victim[k] = 32'h11 + k;
        test_miss("dirty", 1'b1, 10'h055, 10'h3FF, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[12'hFFC + k] !== 32'h11 + k) begin
                errors++; $display("FAIL dirty_mem: addr=%h got %h expected %h", 12'hFFC + k, mem[12'hFFC + k], 32'h11 + k);
            end
        end
    endtask

    task automatic test_glitch();
        for (int k = 0; k < 4; k++) victim[k] = $urandom;
        test_miss("glitch_clean", 1'b0, 10'h123, 10'h0F0, 1'b1);
        test_miss("glitch_dirty", 1'b1, 10'h200, 10'h201, 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            logic [BW-1:0] ra, ea;
            for (int k = 0; k < 4; k++) victim[k] = $urandom;
            ra = BW'($urandom);
            ea = (n % 5 == 0) ? ra : BW'($urandom);
            test_miss("random", 1'($urandom), ra, ea, 1'($urandom));
        end
    endtask

    task automatic test_reset_mid_evict();
        logic [BW-1:0] ea;
        int w0, seen = 0;
        for (int k = 0; k < 4; k++) victim[k] = $urandom;
        ea = BW'($urandom);
        for (int k = 0; k < 4; k++) mem[{ea, 2'(k)}] = ~victim[k];
        w0 = wr_cnt;
        @(negedge clk);
        i_req = 1'b1; i_evict_en = 1'b1; i_evict_addr = ea; i_refill_addr = BW'($urandom);
        @(posedge clk);
        #1 i_req = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (o_mem_we !== 1'b1 || o_word_idx !== 2'd2) begin
            errors++; $display("FAIL rst_evict_pre: got we=%b idx=%0d expected we=1 idx=2", o_mem_we, o_word_idx);
        end
        nrst = 1'b0;
        #1;
        checks++;
        if ({o_readymm, o_word_idx, o_refill_valid, o_refill_word, o_done_mm, o_mem_addr, o_mem_we, o_mem_wdata} !== '0) begin
            errors++; $display("FAIL rst_evict_outputs: got nonzero outputs, expected all 0");
        end
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (o_readymm || o_done_mm || o_mem_we) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL rst_evict_idle: got %0d active cycles after release, expected 0", seen);
        end
        checks++;
        if (wr_cnt - w0 != 2) begin
            errors++; $display("FAIL rst_evict_writes: got %0d writes expected 2", wr_cnt - w0);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[{ea, 2'(k)}] !== (k < 2 ? victim[k] : ~victim[k])) begin
                errors++;
                $display("FAIL rst_evict_mem: word %0d got %h expected %h", k, mem[{ea, 2'(k)}], k < 2 ? victim[k] : ~victim[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int gq[$], dq[$];
        int nref = 0;
        @(negedge clk);
        i_req = 1'b1; i_evict_en = 1'b0; i_refill_addr = BW'($urandom);
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk);
            #1 if (c == 8) i_req = 1'b0;
            @(negedge clk);
            if (o_readymm) gq.push_back(c);
            if (o_done_mm) dq.push_back(c);
            if (o_refill_valid) nref++;
        end
        checks++;
        if (gq.size() != 2 || gq[0] != 1 || gq[1] != 8) begin
            errors++; $display("FAIL b2b_grant: got %0d grants (first c=%0d) expected grants at c=1,8", gq.size(), gq.size() ? gq[0] : -1);
        end
        checks++;
        if (dq.size() != 2 || dq[0] != 6 || dq[1] != 13) begin
            errors++; $display("FAIL b2b_done: got %0d dones (first c=%0d) expected dones at c=6,13", dq.size(), dq.size() ? dq[0] : -1);
        end
        checks++;
        if (nref != 8) begin
            errors++; $display("FAIL b2b_refills: got %0d expected 8", nref);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << MW); i++) mem[i] = $urandom;
        for (int k = 0; k < 4; k++) victim[k] = $urandom;
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_glitch();
        test_reset_mid_evict();
        test_clean_miss();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
